// File: rtl/dccm_pkg.sv
// ============================================================================
// Module      : dccm_pkg
// Description : Shared width, default geometry and pipeline-stage types for
//               the data closely-coupled memory.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package dccm_pkg;

    localparam int          XLEN               = 32;
    localparam logic [31:0] DCCM_BASE_DEFAULT  = 32'h0001_0000;
    localparam int          DCCM_DEPTH_DEFAULT = 4096;

    typedef struct packed {
        logic            valid;
        logic            err;
        logic [XLEN-1:0] data;
    } rd_stage_t;

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic even_parity(input logic [XLEN-1:0] word);
        return ^word;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dccm_ram.sv
// ============================================================================
// Module      : dccm_ram
// Description : 1W/1R word array with write-first bypass; optional per-word
//               parity storage when DCCM_PARITY_EN is defined.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module dccm_ram
    import dccm_pkg::*;
#(
    parameter int DEPTH = DCCM_DEPTH_DEFAULT,
    parameter int AW    = 12
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [XLEN-1:0] rdata,
    output logic            par_err
);

    logic [XLEN-1:0] mem [DEPTH];
    logic            hit;

    assign hit = we && (waddr == raddr);

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = hit ? wdata : mem[raddr];

`ifdef DCCM_PARITY_EN
    logic par_mem [DEPTH];
    logic rpar;

    always_ff @(posedge clk) begin
        if (we) begin
            par_mem[waddr] <= even_parity(wdata);
        end
    end

    assign rpar    = hit ? even_parity(wdata) : par_mem[raddr];
    assign par_err = rpar ^ even_parity(rdata);
`else
    assign par_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/dccm.sv
// ============================================================================
// Module      : dccm
// Description : Data CCM: address decode, fixed-latency read pipeline and
//               error reporting around dccm_ram. Macro DCCM_PARITY_EN adds
//               per-word parity checking.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module dccm
    import dccm_pkg::*;
#(
    parameter logic [XLEN-1:0] DCCM_BASE  = DCCM_BASE_DEFAULT,
    parameter int              DCCM_DEPTH = DCCM_DEPTH_DEFAULT,
    parameter int              RD_LATENCY = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [XLEN-1:0] dccm_raddr,
    input  logic            dccm_rvalid_in,
    output logic [XLEN-1:0] dccm_rdata,
    output logic            dccm_rvalid_out,
    input  logic [XLEN-1:0] dccm_waddr,
    input  logic            dccm_wen,
    input  logic [XLEN-1:0] dccm_wdata,
    output logic            dccm_err
);

    localparam int AW = (DCCM_DEPTH > 1) ? $clog2(DCCM_DEPTH) : 1;

    logic            r_in_range;
    logic            w_in_range;
    logic [AW-1:0]   ridx;
    logic [AW-1:0]   widx;
    logic            ram_we;
    logic [XLEN-1:0] ram_rdata;
    logic            ram_par_err;

    rd_stage_t       stage_d;
    rd_stage_t       pipe_q [RD_LATENCY];
    logic            werr_d;
    logic            werr_q;

    // Addresses below the base must not wrap into the top of the array.
    function automatic logic addr_in_range(input logic [XLEN-1:0] addr);
        logic [XLEN-1:0] offset;
        offset = addr - DCCM_BASE;
        return (addr >= DCCM_BASE) && ((offset >> 2) < XLEN'(DCCM_DEPTH));
    endfunction

    function automatic logic [AW-1:0] word_index(input logic [XLEN-1:0] addr);
        logic [XLEN-1:0] offset;
        offset = addr - DCCM_BASE;
        return offset[AW+1:2];
    endfunction

    assign r_in_range = addr_in_range(dccm_raddr);
    assign w_in_range = addr_in_range(dccm_waddr);
    assign ridx       = word_index(dccm_raddr);
    assign widx       = word_index(dccm_waddr);
    assign ram_we     = dccm_wen & w_in_range;

    dccm_ram #(
        .DEPTH (DCCM_DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .waddr   (widx),
        .wdata   (dccm_wdata),
        .raddr   (ridx),
        .rdata   (ram_rdata),
        .par_err (ram_par_err)
    );

    always_comb begin
        stage_d = '0;
        werr_d  = dccm_wen & ~w_in_range;
        if (dccm_rvalid_in) begin
            stage_d.valid = 1'b1;
            stage_d.err   = ~r_in_range | ram_par_err;
            stage_d.data  = r_in_range ? ram_rdata : '0;
        end
    end

    // Idle stages carry zero data so rdata is zero whenever rvalid_out is low.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
            werr_q <= 1'b0;
        end else begin
            pipe_q[0] <= stage_d;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            werr_q <= werr_d;
        end
    end

    assign dccm_rvalid_out = pipe_q[RD_LATENCY-1].valid;
    assign dccm_rdata      = pipe_q[RD_LATENCY-1].data;
    assign dccm_err        = (pipe_q[RD_LATENCY-1].valid & pipe_q[RD_LATENCY-1].err) | werr_q;

endmodule

`default_nettype wire

// File: tb/tb_dccm.sv
// ============================================================================
// Module      : tb_dccm
// Description : Self-checking bench for dccm: directed vector table, corner
//               sequences and randomized traffic against a word-level model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_dccm;
    import dccm_pkg::*;

    localparam int          LAT   = 3;
    localparam int          DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h0001_0000;

    logic        clk;
    logic        rstn;
    logic [31:0] dccm_raddr;
    logic        dccm_rvalid_in;
    logic [31:0] dccm_rdata;
    logic        dccm_rvalid_out;
    logic [31:0] dccm_waddr;
    logic        dccm_wen;
    logic [31:0] dccm_wdata;
    logic        dccm_err;

    dccm #(
        .DCCM_BASE  (BASE),
        .DCCM_DEPTH (DEPTH),
        .RD_LATENCY (LAT)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .dccm_raddr      (dccm_raddr),
        .dccm_rvalid_in  (dccm_rvalid_in),
        .dccm_rdata      (dccm_rdata),
        .dccm_rvalid_out (dccm_rvalid_out),
        .dccm_waddr      (dccm_waddr),
        .dccm_wen        (dccm_wen),
        .dccm_wdata      (dccm_wdata),
        .dccm_err        (dccm_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-level reference: written words, and expected outputs per cycle.
    logic [31:0] mem_m   [int];
    bit          par_bad [int];
    bit          exp_v   [int];
    logic [31:0] exp_d   [int];
    bit          exp_re  [int];
    bit          exp_we  [int];
    logic [31:0] resp_q  [$];
    int          cyc    = 0;
    int          n_cmp  = 0;
    int          n_bad  = 0;

    function automatic bit in_rng(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASE);
        return (off >= 0) && ((off / 4) < DEPTH);
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE)) / 4);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input bit ren, input logic [31:0] ra,
                        input bit wen, input logic [31:0] wa, input logic [31:0] wd);
        bit          ev;
        logic [31:0] ed;
        bit          ee;
        int          t;
        dccm_rvalid_in = ren;
        dccm_raddr     = ra;
        dccm_wen       = wen;
        dccm_waddr     = wa;
        dccm_wdata     = wd;
        @(posedge clk);
        cyc++;
        if (ren) begin
            t = cyc + LAT - 1;
            exp_v[t] = 1'b1;
            if (!in_rng(ra)) begin
                exp_d[t]  = '0;
                exp_re[t] = 1'b1;
            end else if (wen && in_rng(wa) && idx_of(wa) == idx_of(ra)) begin
                exp_d[t]  = wd;
                exp_re[t] = 1'b0;
            end else begin
                exp_d[t]  = mem_m.exists(idx_of(ra)) ? mem_m[idx_of(ra)] : 32'hxxxx_xxxx;
                exp_re[t] = par_bad.exists(idx_of(ra));
            end
        end
        if (wen) begin
            if (in_rng(wa)) begin
                mem_m[idx_of(wa)] = wd;
                if (par_bad.exists(idx_of(wa))) par_bad.delete(idx_of(wa));
            end else begin
                exp_we[cyc] = 1'b1;
            end
        end
        @(negedge clk);
        ev = exp_v.exists(cyc);
        ed = ev ? exp_d[cyc] : 32'h0;
        ee = (ev && exp_re[cyc]) || exp_we.exists(cyc);
        check("rvalid_out", {31'b0, dccm_rvalid_out}, {31'b0, ev});
        check("rdata", dccm_rdata, ed);
        check("err", {31'b0, dccm_err}, {31'b0, ee});
        if (dccm_rvalid_out) resp_q.push_back(dccm_rdata);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset(input int n);
        dccm_rvalid_in = 1'b0;
        dccm_wen       = 1'b0;
        rstn           = 1'b0;
        exp_v.delete();
        exp_d.delete();
        exp_re.delete();
        exp_we.delete();
        #1;
        check("rst_rvalid", {31'b0, dccm_rvalid_out}, 32'h0);
        check("rst_rdata", dccm_rdata, 32'h0);
        check("rst_err", {31'b0, dccm_err}, 32'h0);
        repeat (n) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            check("rst_rvalid", {31'b0, dccm_rvalid_out}, 32'h0);
            check("rst_rdata", dccm_rdata, 32'h0);
            check("rst_err", {31'b0, dccm_err}, 32'h0);
        end
        rstn = 1'b1;
    endtask

    function automatic logic [31:0] rnd_addr();
        case ($urandom_range(0, 9))
            0:       return BASE - 32'(4 * $urandom_range(1, 8)) + 32'($urandom_range(0, 3));
            1:       return BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 8));
            default: return BASE + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(0, 3));
        endcase
    endfunction

    typedef struct {
        string       name;
        bit          wen;
        bit          same;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [31:0] ra;
        logic [31:0] exp_d;
        bit          exp_e;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{"word0",        1, 0, 32'h0001_0000, 32'hA5A5_0001, 32'h0001_0000, 32'hA5A5_0001, 0};
        vecs[1] = '{"wr_then_rd",   1, 0, 32'h0001_0010, 32'hDEAD_BEEF, 32'h0001_0010, 32'hDEAD_BEEF, 0};
        vecs[2] = '{"same_cycle",   1, 1, 32'h0001_0020, 32'h1234_5678, 32'h0001_0020, 32'h1234_5678, 0};
        vecs[3] = '{"last_word",    1, 0, 32'h0001_3FFC, 32'h0BAD_F00D, 32'h0001_3FFF, 32'h0BAD_F00D, 0};
        vecs[4] = '{"oor_rd_wr",    1, 1, 32'h0001_4000, 32'hFFFF_FFFF, 32'h0000_0FFC, 32'h0000_0000, 1};
        vecs[5] = '{"no_wrap",      0, 0, 32'h0,         32'h0,         32'h0001_0000, 32'hA5A5_0001, 0};
        vecs[6] = '{"low_bits",     0, 0, 32'h0,         32'h0,         32'h0001_0013, 32'hDEAD_BEEF, 0};
        vecs[7] = '{"word1",        1, 0, 32'h0001_0004, 32'h1111_2222, 32'h0001_0004, 32'h1111_2222, 0};
        vecs[8] = '{"rd_wr_differ", 1, 1, 32'h0001_0008, 32'h5555_AAAA, 32'h0001_0010, 32'hDEAD_BEEF, 0};
        vecs[9] = '{"word3",        1, 0, 32'h0001_000C, 32'h3333_4444, 32'h0001_000C, 32'h3333_4444, 0};

        rstn           = 1'b0;
        dccm_rvalid_in = 1'b0;
        dccm_raddr     = '0;
        dccm_wen       = 1'b0;
        dccm_waddr     = '0;
        dccm_wdata     = '0;
        @(negedge clk);
        do_reset(2);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wen && !vecs[i].same) step(1'b0, 32'h0, 1'b1, vecs[i].wa, vecs[i].wd);
            step(1'b1, vecs[i].ra, vecs[i].wen && vecs[i].same, vecs[i].wa, vecs[i].wd);
            idle(LAT - 1);
            check({"vec_valid_", vecs[i].name}, {31'b0, dccm_rvalid_out}, 32'h1);
            check({"vec_data_", vecs[i].name}, dccm_rdata, vecs[i].exp_d);
            check({"vec_err_", vecs[i].name}, {31'b0, dccm_err}, {31'b0, vecs[i].exp_e});
        end

        // Four back-to-back reads must return four consecutive responses in order.
        resp_q.delete();
        for (int i = 0; i < 4; i++) step(1'b1, BASE + 32'(4 * i), 1'b0, 32'h0, 32'h0);
        idle(LAT);
        check("b2b_count", resp_q.size(), 4);
        if (resp_q.size() == 4) begin
            check("b2b_0", resp_q[0], 32'hA5A5_0001);
            check("b2b_1", resp_q[1], 32'h1111_2222);
            check("b2b_2", resp_q[2], 32'h5555_AAAA);
            check("b2b_3", resp_q[3], 32'h3333_4444);
        end

        // A write after the read was sampled must not alter its response.
        resp_q.delete();
        step(1'b1, 32'h0001_0010, 1'b0, 32'h0, 32'h0);
        step(1'b0, 32'h0, 1'b1, 32'h0001_0010, 32'hCAFE_0000);
        idle(LAT);
        check("inflight_count", resp_q.size(), 1);
        if (resp_q.size() == 1) check("inflight_data", resp_q[0], 32'hDEAD_BEEF);

        // Reset one cycle after a read: the read must never be answered.
        resp_q.delete();
        step(1'b1, 32'h0001_0000, 1'b0, 32'h0, 32'h0);
        do_reset(1);
        idle(LAT + 2);
        check("rst_discard", resp_q.size(), 0);
        resp_q.delete();
        step(1'b1, 32'h0001_0004, 1'b0, 32'h0, 32'h0);
        idle(LAT);
        check("persist_count", resp_q.size(), 1);
        if (resp_q.size() == 1) check("persist_data", resp_q[0], 32'h1111_2222);

`ifdef DCCM_PARITY_EN
        step(1'b0, 32'h0, 1'b1, 32'h0001_0014, 32'h0F0F_1234);
        dut.u_ram.par_mem[5] = ~dut.u_ram.par_mem[5];
        par_bad[5] = 1'b1;
        step(1'b1, 32'h0001_0014, 1'b0, 32'h0, 32'h0);
        idle(LAT - 1);
        check("par_valid", {31'b0, dccm_rvalid_out}, 32'h1);
        check("par_err", {31'b0, dccm_err}, 32'h1);
        check("par_data", dccm_rdata, 32'h0F0F_1234);
`endif

        // Randomized traffic over a preloaded window plus out-of-range addresses.
        for (int i = 0; i < 64; i++) step(1'b0, 32'h0, 1'b1, BASE + 32'(4 * i), $urandom);
        for (int i = 0; i < 600; i++) begin
            logic [31:0] ra;
            logic [31:0] wa;
            bit          ren;
            bit          wen;
            ra  = rnd_addr();
            wa  = ($urandom_range(0, 3) == 0) ? ra : rnd_addr();
            ren = ($urandom_range(0, 3) != 0);
            wen = ($urandom_range(0, 1) != 0);
            if (i == 300) do_reset(1);
            step(ren, ra, wen, wa, $urandom);
        end
        idle(LAT + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
